aud_recorder: RTL and testbench

AUD_RECORDER -- requirements
Module: aud_recorder

---
 rtl/aud_pkg.sv | 15 +
 rtl/aud_i2s_deser.sv | 44 ++++
 rtl/aud_recorder.sv | 113 +++++++++++
 tb/tb_aud_recorder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// Shared definitions for the audio recorder and player datapaths.
package aud_pkg;
  localparam int DATA_W    = 16;
  localparam int I2S_DELAY = 1;  // MSB follows the LRCK edge by one BCLK
  localparam int STATE_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_LEFT  = 3'd2,
    S_RIGHT = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } aud_state_t;
endpackage

// File: rtl/aud_i2s_deser.sv
// I2S deserialiser: LRCK edge detect, bit counter and MSB-first shift register.
// Latency: edges flagged in the sampling cycle; o_word complete in the cycle o_last is high.
// Backpressure: none; the serial stream cannot be stalled, i_en low discards the partial word.
module aud_i2s_deser #(
  parameter int DATA_W = aud_pkg::DATA_W
) (
  input  logic              i_bclk,
  input  logic              i_rst,
  input  logic              i_adclrck,
  input  logic              i_adcdat,
  input  logic              i_en,
  output logic              o_fall,
  output logic              o_rise,
  output logic              o_last,
  output logic [DATA_W-1:0] o_word
);
  localparam int CNT_W = $clog2(DATA_W);

  logic              lrck_d;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-2:0] shift_reg;

  always_ff @(posedge i_bclk) begin
    if (i_rst) begin
      lrck_d    <= 1'b0;
      count     <= '0;
      shift_reg <= '0;
    end else begin
      lrck_d <= i_adclrck;
      if (!i_en) begin
        count     <= '0;
        shift_reg <= '0;
      end else begin
        shift_reg <= o_word[DATA_W-2:0];
        count     <= o_last ? '0 : count + CNT_W'(1);
      end
    end
  end

  assign o_fall = lrck_d & ~i_adclrck;
  assign o_rise = ~lrck_d & i_adclrck;
  assign o_last = (count == CNT_W'(DATA_W - 1));
  assign o_word = {shift_reg, i_adcdat};
endmodule

// File: rtl/aud_recorder.sv
// I2S ADC recorder writing samples to sequential SRAM addresses; AUD_RECORDER_STEREO_EN adds the right channel.
// Latency: o_valid one BCLK after the last data bit; address advances the cycle after o_valid.
// Backpressure: none; i_pause gates whole frames at the falling LRCK edge only.
module aud_recorder #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
  input  logic              i_bclk,
  input  logic              i_rst,
  input  logic              i_adclrck,
  input  logic              i_adcdat,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_valid,
  output logic              o_full,
  output logic [2:0]        o_state
);
  import aud_pkg::*;

  aud_state_t        state;
  logic              r_run;
  logic              fall, rise, last, en, capturing;
  logic [DATA_W-1:0] word;

  // A frame edge mid-word clears the deserialiser so capture restarts on that edge.
  assign capturing = (state == S_LEFT) || ((state == S_RIGHT) && r_run);
  assign en        = capturing && !i_stop && (last || !(fall || rise));
  assign o_state   = state;

  aud_i2s_deser #(.DATA_W(DATA_W)) u_deser (
    .i_bclk   (i_bclk),
    .i_rst    (i_rst),
    .i_adclrck(i_adclrck),
    .i_adcdat (i_adcdat),
    .i_en     (en),
    .o_fall   (fall),
    .o_rise   (rise),
    .o_last   (last),
    .o_word   (word)
  );

  always_ff @(posedge i_bclk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      r_run     <= 1'b0;
      o_data    <= '0;
      o_address <= '0;
      o_valid   <= 1'b0;
      o_full    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_stop) begin
        state <= S_IDLE;
        r_run <= 1'b0;
      end else if (o_valid && (o_address == MAX_ADDR)) begin
        o_full <= 1'b1;
        state  <= S_DONE;
        r_run  <= 1'b0;
      end else begin
        if (o_valid) o_address <= o_address + ADDR_W'(1);
        unique case (state)
          S_IDLE, S_DONE: begin
            if (i_start) begin
              state     <= S_SYNC;
              o_address <= '0;
              o_full    <= 1'b0;
            end
          end
          S_SYNC, S_WAIT: begin
            if (fall && !i_pause) state <= S_LEFT;
          end
          S_LEFT: begin
            if (last) begin
              o_data  <= word;
              o_valid <= 1'b1;
`ifdef AUD_RECORDER_STEREO_EN
              state   <= S_RIGHT;
              r_run   <= rise;
`else
              state   <= (fall && !i_pause) ? S_LEFT : S_WAIT;
`endif
            end else if (fall) begin
              state <= i_pause ? S_WAIT : S_LEFT;
            end else if (rise) begin
              state <= S_WAIT;
            end
          end
`ifdef AUD_RECORDER_STEREO_EN
          // r_run low: left written, still waiting for the rising LRCK edge.
          S_RIGHT: begin
            if (r_run && last) begin
              o_data  <= word;
              o_valid <= 1'b1;
              r_run   <= 1'b0;
              state   <= (fall && !i_pause) ? S_LEFT : S_WAIT;
            end else if (fall) begin
              r_run <= 1'b0;
              state <= i_pause ? S_WAIT : S_LEFT;
            end else if (rise) begin
              r_run <= 1'b1;
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_aud_recorder.sv
// Self-checking bench for aud_recorder: table vectors, corner sequences and random frames vs a frame-level model.
module tb_aud_recorder;
  localparam logic [19:0] MAX = 20'd3;
`ifdef AUD_RECORDER_STEREO_EN
  localparam int NCH = 2;
`else
  localparam int NCH = 1;
`endif
  localparam logic [2:0] ST_IDLE = 3'd0, ST_SYNC = 3'd1, ST_LEFT = 3'd2, ST_DONE = 3'd5;

  logic        i_bclk = 1'b0;
  logic        i_rst, i_adclrck, i_adcdat, i_start, i_pause, i_stop;
  logic [15:0] o_data;
  logic [19:0] o_address;
  logic        o_valid, o_full;
  logic [2:0]  o_state;

  always #5 i_bclk = ~i_bclk;

  aud_recorder #(.DATA_W(16), .ADDR_W(20), .MAX_ADDR(MAX)) dut (
    .i_bclk(i_bclk), .i_rst(i_rst), .i_adclrck(i_adclrck), .i_adcdat(i_adcdat),
    .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
    .o_data(o_data), .o_address(o_address), .o_valid(o_valid), .o_full(o_full),
    .o_state(o_state)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        p;
    logic        wl;
    logic [19:0] al;
    logic        wr;
    logic [19:0] ar;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  logic        prev_lsb = 1'b0;
  logic [35:0] got_q[$];
  logic [35:0] exp_q[$];
  logic [15:0] fr_l[$];
  logic [15:0] fr_r[$];
  logic        fr_p[$];
  logic [19:0] m_addr;
  logic        m_full;
  vec_t        tbl[6];

  always @(negedge i_bclk) if (o_valid === 1'b1) got_q.push_back({o_address, o_data});

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, need %0h", nm, got, exp);
    end
  endtask

  // Reference: every unpaused frame stores its channels at consecutive addresses until MAX is written.
  task automatic run_model();
    logic [19:0] a;
    logic        f;
    a = '0;
    f = 1'b0;
    exp_q.delete();
    foreach (fr_l[i]) begin
      if (!fr_p[i]) begin
        for (int ch = 0; ch < NCH; ch++) begin
          if (!f) begin
            exp_q.push_back({a, (ch == 0) ? fr_l[i] : fr_r[i]});
            if (a == MAX) f = 1'b1;
            else a = a + 20'd1;
          end
        end
      end
    end
    m_addr = a;
    m_full = f;
  endtask

  task automatic cmp_writes(input string tag);
    chk($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  // One 32-BCLK I2S frame: LRCK low 16 / high 16, each word MSB first one BCLK after its edge.
  task automatic drive_frame(input logic [15:0] l, input logic [15:0] r, input logic p,
                             input int pk, input int nk);
    for (int k = 0; k < nk; k++) begin
      @(negedge i_bclk);
      if (k == 0) i_pause = p;
      if (k == pk) i_pause = 1'b1;
      i_adclrck = (k >= 16);
      if (k == 0) i_adcdat = prev_lsb;
      else if (k <= 16) i_adcdat = l[16-k];
      else i_adcdat = r[32-k];
    end
    prev_lsb = r[0];
  endtask

  task automatic play(input logic [15:0] l, input logic [15:0] r, input logic p, input int pk);
    fr_l.push_back(l);
    fr_r.push_back(r);
    fr_p.push_back(p);
    drive_frame(l, r, p, pk, 32);
  endtask

  task automatic tail();
    @(negedge i_bclk);
    i_adclrck = 1'b0;
    i_adcdat  = prev_lsb;
    repeat (3) @(negedge i_bclk);
  endtask

  task automatic restart();
    @(negedge i_bclk);
    i_stop = 1'b1; i_start = 1'b0; i_pause = 1'b0; i_adclrck = 1'b1;
    @(negedge i_bclk);
    i_stop = 1'b0; i_start = 1'b1;
    @(negedge i_bclk);
    i_start = 1'b0;
    got_q.delete();
    fr_l.delete(); fr_r.delete(); fr_p.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, n;
    i_rst = 1'b1; i_adclrck = 1'b1; i_adcdat = 1'b0;
    i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
    repeat (3) @(negedge i_bclk);
    chk("rst_state", o_state, ST_IDLE);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_full", o_full, 1'b0);
    chk("rst_addr", o_address, 20'd0);
    chk("rst_data", o_data, 16'd0);

    // First recording straight out of reset.
    @(negedge i_bclk); i_rst = 1'b0;
    @(negedge i_bclk); i_start = 1'b1;
    @(negedge i_bclk); i_start = 1'b0;
    chk("start_sync", o_state, ST_SYNC);
    play(16'hA5C3, 16'h0F0F, 1'b0, -1);
    tail();
    run_model();
    cmp_writes("first");
    chk("first_addr", o_address, m_addr);

    // Stop in the middle of a word.
    restart();
    play(16'h1111, 16'h2222, 1'b0, -1);
    drive_frame(16'h3C3C, 16'h4444, 1'b0, -1, 7);
    @(negedge i_bclk);
    chk("stop_pre_left", o_state, ST_LEFT);
    i_stop = 1'b1;
    i_adcdat = 1'b1;
    @(negedge i_bclk);
    i_stop = 1'b0;
    chk("stop_idle", o_state, ST_IDLE);
    chk("stop_valid", o_valid, 1'b0);
    run_model();
    chk("stop_addr", o_address, m_addr);
    repeat (20) @(negedge i_bclk);
    cmp_writes("stop");
    i_stop = 1'b1; i_start = 1'b1;
    @(negedge i_bclk);
    i_stop = 1'b0; i_start = 1'b0;
    chk("stop_beats_start", o_state, ST_IDLE);

    // Vector table: ordinary writes, one paused frame, running into MAX.
`ifdef AUD_RECORDER_STEREO_EN
    tbl[0] = '{16'h0001, 16'h1111, 1'b0, 1'b1, 20'd0, 1'b1, 20'd1};
    tbl[1] = '{16'h8000, 16'h2222, 1'b0, 1'b1, 20'd2, 1'b1, 20'd3};
    tbl[2] = '{16'h5555, 16'h3333, 1'b1, 1'b0, 20'd0, 1'b0, 20'd0};
    tbl[3] = '{16'hFFFF, 16'h4444, 1'b0, 1'b0, 20'd0, 1'b0, 20'd0};
    tbl[4] = '{16'h1357, 16'h5555, 1'b0, 1'b0, 20'd0, 1'b0, 20'd0};
    tbl[5] = '{16'h2468, 16'h6666, 1'b0, 1'b0, 20'd0, 1'b0, 20'd0};
`else
    tbl[0] = '{16'h0001, 16'h1111, 1'b0, 1'b1, 20'd0, 1'b0, 20'd0};
    tbl[1] = '{16'h8000, 16'h2222, 1'b0, 1'b1, 20'd1, 1'b0, 20'd0};
    tbl[2] = '{16'h5555, 16'h3333, 1'b1, 1'b0, 20'd0, 1'b0, 20'd0};
    tbl[3] = '{16'hFFFF, 16'h4444, 1'b0, 1'b1, 20'd2, 1'b0, 20'd0};
    tbl[4] = '{16'h1357, 16'h5555, 1'b0, 1'b1, 20'd3, 1'b0, 20'd0};
    tbl[5] = '{16'h2468, 16'h6666, 1'b0, 1'b0, 20'd0, 1'b0, 20'd0};
`endif
    restart();
    for (int i = 0; i < 6; i++) play(tbl[i].l, tbl[i].r, tbl[i].p, -1);
    tail();
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].wl) begin
        if (idx < got_q.size()) chk($sformatf("tbl%0d_left", i), got_q[idx], {tbl[i].al, tbl[i].l});
        idx++;
      end
      if (tbl[i].wr) begin
        if (idx < got_q.size()) chk($sformatf("tbl%0d_right", i), got_q[idx], {tbl[i].ar, tbl[i].r});
        idx++;
      end
    end
    chk("tbl_count", got_q.size(), idx);
    chk("tbl_full", o_full, 1'b1);
    chk("tbl_done", o_state, ST_DONE);
    chk("tbl_addr", o_address, MAX);

    // Short frame: rising edge arrives mid-word.
    restart();
    for (int k = 0; k < 26; k++) begin
      @(negedge i_bclk);
      i_adclrck = (k >= 10);
      i_adcdat  = 1'($urandom_range(0, 1));
    end
    play(16'hBEEF, 16'h0BAD, 1'b0, -1);
    play(16'h7E57, 16'hC0DE, 1'b0, -1);
    tail();
    run_model();
    cmp_writes("abort");
    chk("abort_addr", o_address, m_addr);

    // Pause raised mid-frame and held across two frames.
    restart();
    play(16'h0A0A, 16'hA0A0, 1'b0, 7);
    play(16'h0B0B, 16'hB0B0, 1'b1, -1);
    play(16'h0C0C, 16'hC0C0, 1'b1, -1);
    play(16'h0D0D, 16'hD0D0, 1'b0, -1);
    tail();
    run_model();
    cmp_writes("pause");
    chk("pause_addr", o_address, m_addr);

    // Left/right pair.
    restart();
    play(16'h1234, 16'h5678, 1'b0, -1);
    tail();
    run_model();
    cmp_writes("pair");

    // Random frames with random pause.
    for (int rnd = 0; rnd < 6; rnd++) begin
      restart();
      n = $urandom_range(3, 7);
      for (int i = 0; i < n; i++)
        play(16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0), -1);
      tail();
      run_model();
      cmp_writes($sformatf("rnd%0d", rnd));
      chk($sformatf("rnd%0d_addr", rnd), o_address, m_addr);
      chk($sformatf("rnd%0d_full", rnd), o_full, m_full);
      if (m_full) chk($sformatf("rnd%0d_done", rnd), o_state, ST_DONE);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
